// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
// Imported by the controller and its register file.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    localparam int CMD_RNW = 7;
    localparam int CMD_AI  = 6;

endpackage

// File: rtl/spi_reg_file.sv
// NREG x 8 register file: one write port, one combinational read port.
// Address 0 has no storage; it reads status_i and shows 0 on regs_o.
module spi_reg_file
    import spi_reg_pkg::*;
#(
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00,
    localparam int         NREG      = 2 ** ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [7:0]          wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    input  logic [7:0]          status_i,
    output logic [7:0]          rdata_o,
    output logic [8*NREG-1:0]   regs_o
);

    logic [7:0] mem_q [1:NREG-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k < NREG; k++) begin
                mem_q[k] <= RESET_VAL;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = status_i;
        if (raddr_i != '0) begin
            rdata_o = mem_q[raddr_i];
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 1; k < NREG; k++) begin
            regs_o[k*8 +: 8] = mem_q[k];
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Byte-level SPI command controller: decodes CMD/data frames from
// SPI_slave into register writes or transmit-data preloads.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00,
    localparam int         NREG      = 2 ** ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ena_i,
    input  logic                cs_i,
    input  logic                done_i,
    input  logic [7:0]          rx_data_i,
    output logic                tx_ena_o,
    output logic [7:0]          tx_data_o,
    input  logic [7:0]          status_i,
    output logic [8*NREG-1:0]   regs_o,
    output logic                wr_strobe_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic                err_o
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ai_q, ai_d;
    logic                tx_ena_q, tx_ena_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                err_q, err_d;
    logic                wait_cs_q, wait_cs_d;

    logic                we;
    logic [ADDR_W-1:0]   raddr;
    logic [7:0]          rdata;
    logic                byte_ok;
    logic [5:0]          cmd_hi;
    logic [ADDR_W-1:0]   cmd_addr;

    spi_reg_file #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_VAL)
    ) u_file (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (we),
        .waddr_i  (addr_q),
        .wdata_i  (rx_data_i),
        .raddr_i  (raddr),
        .status_i (status_i),
        .rdata_o  (rdata),
        .regs_o   (regs_o)
    );

    assign byte_ok  = ena_i & done_i & cs_i;
    assign cmd_hi   = rx_data_i[5:0] >> ADDR_W;
    assign cmd_addr = rx_data_i[ADDR_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            ai_q        <= 1'b0;
            tx_ena_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= 1'b0;
            wait_cs_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ai_q        <= ai_d;
            tx_ena_q    <= tx_ena_d;
            tx_data_q   <= tx_data_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
            wait_cs_q   <= wait_cs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ai_d      = ai_q;
        tx_ena_d  = 1'b0;
        tx_data_d = 8'h00;
        err_d     = err_q;
        // a frame cut by reset must not be mistaken for a fresh CMD
        wait_cs_d = wait_cs_q & cs_i;
        we        = 1'b0;
        raddr     = addr_q;

        if (!cs_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    raddr = cmd_addr;
                    if (byte_ok && !wait_cs_q) begin
                        addr_d = cmd_addr;
                        ai_d   = rx_data_i[CMD_AI];
                        if (cmd_hi != '0) begin
                            err_d = 1'b1;
                        end
                        if (rx_data_i[CMD_RNW]) begin
                            state_d   = ST_READ;
                            tx_ena_d  = 1'b1;
                            tx_data_d = rdata;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (byte_ok) begin
                        if (addr_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            we = 1'b1;
                        end
                        if (ai_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_READ: begin
                    tx_ena_d  = 1'b1;
                    tx_data_d = tx_data_q;
                    raddr     = ai_q ? addr_q + ADDR_W'(1) : addr_q;
                    if (byte_ok) begin
                        addr_d    = raddr;
                        tx_data_d = rdata;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        wr_strobe_d = we;
        wr_addr_d   = we ? addr_q : wr_addr_q;
    end

    assign tx_ena_o    = tx_ena_q;
    assign tx_data_o   = tx_data_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed vector bench for spi_reg_ctrl (ADDR_W = 4).
// Table-driven frames plus hand-written reset and enable sequences.
module tb_spi_reg_ctrl;

    localparam int AW   = 4;
    localparam int NREG = 2 ** AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              cs;
    logic              done;
    logic [7:0]        rx;
    logic [7:0]        status;
    logic              tx_ena;
    logic [7:0]        tx_data;
    logic [8*NREG-1:0] regs;
    logic              stb;
    logic [AW-1:0]     waddr;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_reg_ctrl #(
        .ADDR_W    (AW),
        .RESET_VAL (8'h00)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ena_i       (ena),
        .cs_i        (cs),
        .done_i      (done),
        .rx_data_i   (rx),
        .tx_ena_o    (tx_ena),
        .tx_data_o   (tx_data),
        .status_i    (status),
        .regs_o      (regs),
        .wr_strobe_o (stb),
        .wr_addr_o   (waddr),
        .err_o       (err)
    );

    typedef struct {
        logic       cs;
        logic       dn;
        logic [7:0] rx;
        logic [7:0] st;
        logic       e_ena;
        logic [7:0] e_txd;
        logic       e_stb;
        logic [3:0] e_wa;
        logic       e_err;
        int         ridx;
        logic [7:0] rval;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic c, input logic d, input logic [7:0] r,
                       input logic [7:0] s, input logic en,
                       input logic [7:0] td, input logic sb,
                       input logic [3:0] wa, input logic er,
                       input int ri, input logic [7:0] rv);
        vec_t v;
        v.cs = c; v.dn = d; v.rx = r; v.st = s;
        v.e_ena = en; v.e_txd = td; v.e_stb = sb;
        v.e_wa = wa; v.e_err = er; v.ridx = ri; v.rval = rv;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int k);
        return regs[k*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic d, input logic [7:0] r);
        cs = c; done = d; rx = r;
        tick();
        done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; cs = 1'b0; done = 1'b0;
        rx = 8'h00; status = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_tx_ena", 32'(tx_ena), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_strobe", 32'(stb), 32'h0);
        chk("rst_waddr", 32'(waddr), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_regs_zero", 32'(regs == '0), 32'h1);

        //  cs dn rx     st     ena txd    stb wa   err ridx rval
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'h0, 0, 2,  8'h00);
        add(1, 1, 8'h42, 8'h00, 0, 8'h00, 0, 4'h0, 0, 2,  8'h00);
        add(1, 1, 8'hA5, 8'h00, 0, 8'h00, 1, 4'h2, 0, 2,  8'hA5);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'h2, 0, 3,  8'h00);
        add(1, 1, 8'h5A, 8'h00, 0, 8'h00, 1, 4'h3, 0, 3,  8'h5A);
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'h3, 0, 3,  8'h5A);
        add(1, 1, 8'h4F, 8'h00, 0, 8'h00, 0, 4'h3, 0, 15, 8'h00);
        add(1, 1, 8'h11, 8'h00, 0, 8'h00, 1, 4'hF, 0, 15, 8'h11);
        add(1, 1, 8'h22, 8'h00, 0, 8'h00, 0, 4'hF, 1, 0,  8'h00);
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'hF, 1, 15, 8'h11);
        add(1, 1, 8'h45, 8'h00, 0, 8'h00, 0, 4'hF, 1, 5,  8'h00);
        add(1, 1, 8'hC3, 8'h00, 0, 8'h00, 1, 4'h5, 1, 5,  8'hC3);
        add(1, 1, 8'h3C, 8'h00, 0, 8'h00, 1, 4'h6, 1, 6,  8'h3C);
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'h6, 1, 6,  8'h3C);
        add(1, 1, 8'hC5, 8'h00, 1, 8'hC3, 0, 4'h6, 1, 5,  8'hC3);
        add(1, 0, 8'h00, 8'h00, 1, 8'hC3, 0, 4'h6, 1, 5,  8'hC3);
        add(1, 1, 8'hFF, 8'h00, 1, 8'h3C, 0, 4'h6, 1, 7,  8'h00);
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'h6, 1, 7,  8'h00);
        add(1, 1, 8'h80, 8'h7E, 1, 8'h7E, 0, 4'h6, 1, 0,  8'h00);
        add(1, 1, 8'h55, 8'h7E, 1, 8'h7E, 0, 4'h6, 1, 5,  8'hC3);
        add(1, 1, 8'hAA, 8'h7E, 1, 8'h7E, 0, 4'h6, 1, 0,  8'h00);
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'h6, 1, 0,  8'h00);
        add(1, 1, 8'h03, 8'h00, 0, 8'h00, 0, 4'h6, 1, 3,  8'h5A);
        add(0, 1, 8'h77, 8'h00, 0, 8'h00, 0, 4'h6, 1, 3,  8'h5A);
        add(1, 1, 8'h01, 8'h00, 0, 8'h00, 0, 4'h6, 1, 1,  8'h00);
        add(1, 1, 8'h99, 8'h00, 0, 8'h00, 1, 4'h1, 1, 1,  8'h99);
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'h1, 1, 1,  8'h99);

        foreach (vq[i]) begin
            status = vq[i].st;
            drive(vq[i].cs, vq[i].dn, vq[i].rx);
            chk($sformatf("v%0d_tx_ena", i), 32'(tx_ena), 32'(vq[i].e_ena));
            chk($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vq[i].e_txd));
            chk($sformatf("v%0d_strobe", i), 32'(stb), 32'(vq[i].e_stb));
            chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(vq[i].e_wa));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vq[i].e_err));
            chk($sformatf("v%0d_reg%0d", i, vq[i].ridx),
                32'(reg_at(vq[i].ridx)), 32'(vq[i].rval));
        end
        status = 8'h00;

        // reset in the middle of a read frame
        drive(1, 1, 8'hC5);
        chk("mid_read_tx", 32'(tx_data), 32'hC3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_read_tx_ena", 32'(tx_ena), 32'h0);
        chk("rst_read_tx_data", 32'(tx_data), 32'h00);
        chk("rst_read_regs", 32'(regs == '0), 32'h1);
        chk("rst_read_err", 32'(err), 32'h0);
        // cs still high: bytes must not be taken as a CMD
        drive(1, 1, 8'h30);
        chk("post_rst_no_err", 32'(err), 32'h0);
        drive(1, 1, 8'h42);
        drive(1, 1, 8'hA5);
        chk("post_rst_no_strobe", 32'(stb), 32'h0);
        chk("post_rst_reg2", 32'(reg_at(2)), 32'h00);
        drive(0, 0, 8'h00);
        drive(1, 1, 8'h30);
        chk("cmd_hi_bits_err", 32'(err), 32'h1);
        drive(1, 1, 8'hEE);
        chk("addr0_no_strobe", 32'(stb), 32'h0);
        drive(0, 0, 8'h00);

        // enable low blocks done_i but not the cs fall
        drive(1, 1, 8'h02);
        ena = 1'b0;
        drive(1, 1, 8'h44);
        chk("ena_lo_strobe", 32'(stb), 32'h0);
        chk("ena_lo_reg2", 32'(reg_at(2)), 32'h00);
        ena = 1'b1;
        drive(1, 1, 8'h66);
        chk("ena_hi_strobe", 32'(stb), 32'h1);
        chk("ena_hi_waddr", 32'(waddr), 32'h2);
        chk("ena_hi_reg2", 32'(reg_at(2)), 32'h66);
        ena = 1'b0;
        drive(0, 0, 8'h00);
        ena = 1'b1;
        drive(1, 1, 8'h82);
        chk("read_after_ena_tx_ena", 32'(tx_ena), 32'h1);
        chk("read_after_ena_tx", 32'(tx_data), 32'h66);
        drive(0, 0, 8'h00);
        chk("cs_low_tx_ena", 32'(tx_ena), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Byte-level command controller that sequences the `SPI_slave` datapath and maps it onto a small register file. It consumes each received byte (`done`/`rx_data`) and decodes command/address/data frames. It writes registers or preloads read data into the slave's transmit path (`tx_ena`/`tx_data`). It sits between `SPI_slave` and fabric logic, which sees the registers as parallel outputs plus a write strobe.

## Interface
Parameters:
- `ADDR_W`, 4: register address width, 1..6; `NREG = 2**ADDR_W` registers of 8 bits.
- `RESET_VAL`, 8'h00: reset value of every writable register.

Ports:
- `clk_i` in 1: system clock; the only clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `ena_i` in 1: block enable; when low, `done_i` is ignored and the FSM holds.
- `cs_i` in 1: chip select mirrored from the SPI bus; high = frame active.
- `done_i` in 1: one-cycle pulse from `SPI_slave`, one byte received.
- `rx_data_i` in 8: received byte, valid while `done_i` is high.
- `tx_ena_o` out 1: to `SPI_slave` `tx_ena`; transmit data valid.
- `tx_data_o` out 8: to `SPI_slave` `tx_data`.
- `status_i` in 8: read-only value returned at address 0.
- `regs_o` out 8*NREG: flattened register file; byte k = register k; byte 0 is always 8'h00.
- `wr_strobe_o` out 1: one-cycle pulse on each accepted register write.
- `wr_addr_o` out ADDR_W: address of that write, valid with `wr_strobe_o`.
- `err_o` out 1: sticky; set on write to address 0 or on a command byte with bits [5:ADDR_W] nonzero; cleared only by reset.

## Operation
- Frame = bytes received while `cs_i` high. The first byte is CMD: bit7 = R/nW (1 = read), bit6 = AI (auto-increment), bits[ADDR_W-1:0] = start address. Remaining bits are ignored except for the `err_o` check.
- FSM states: IDLE, WRITE, READ.
- IDLE: on `done_i`, latch the address and AI. Go to READ if bit7 = 1, else to WRITE.
- WRITE: each `done_i` writes `rx_data_i` to reg[addr] and pulses `wr_strobe_o`/`wr_addr_o`. Address 0 is not written, sets `err_o`, and raises no strobe. If AI = 1, addr increments after each byte, wrapping NREG-1 -> 0.
- READ: on entry, `tx_data_o` = reg[addr], with address 0 returning `status_i` sampled that cycle, and `tx_ena_o` = 1. On each `done_i`, if AI = 1, advance addr (wrapping) and reload `tx_data_o`; if AI = 0, reload the same address. Received bytes in READ are discarded.
- `cs_i` low in any state: next state IDLE, `tx_ena_o` = 0, `tx_data_o` = 8'h00.
- Outside READ, `tx_ena_o` = 0 and `tx_data_o` = 8'h00.

## Timing
- Reset values: `tx_ena_o` 0, `tx_data_o` 8'h00, `wr_strobe_o` 0, `wr_addr_o` 0, `err_o` 0, all registers `RESET_VAL`, register 0 reads 8'h00 on `regs_o`, FSM IDLE.
- Write latency: `done_i` in cycle N -> `regs_o` updated and `wr_strobe_o` high in cycle N+1, for exactly one cycle.
- Read latency: CMD `done_i` in cycle N -> `tx_ena_o`/`tx_data_o` valid in cycle N+1 and held until the next `done_i` + 1 or until `cs_i` falls.
- `done_i` and `cs_i` low in the same cycle: `cs_i` wins, the byte is discarded, and no write occurs.
- `rst_i` mid-frame: everything returns to reset values next cycle. Bytes after the reset are treated as a new CMD only after `cs_i` has been low at least one cycle.
- `ena_i` low: no state or register changes from `done_i`. A `cs_i` fall still forces IDLE.

## Structure
- Package `spi_reg_pkg`: FSM state enum (IDLE, WRITE, READ), CMD bit positions (`CMD_RNW = 7`, `CMD_AI = 6`).
- Sub-module `spi_reg_file`: NREG x 8 storage, one write port, one combinational read port, address 0 hard-wired to read `status_i`. The controller holds the FSM, address counter and tx register.

## Test plan
- Write, AI = 1: CMD 8'h42, data 8'hA5, 8'h5A -> reg2 = A5, reg3 = 5A; two strobes with `wr_addr_o` 2 then 3; `err_o` 0.
- Wrap: ADDR_W = 4, CMD 8'h4F, data 11, 22 -> reg15 = 11, reg0 untouched, `err_o` = 1, only one strobe.
- Read, AI = 1: reg5 = C3, reg6 = 3C, CMD 8'hC5 -> `tx_data_o` C3 one cycle after CMD done, 3C one cycle after next done; `tx_ena_o` high throughout.
- Read, AI = 0, addr 0, `status_i` = 8'h7E: CMD 8'h80 -> `tx_data_o` = 7E after every byte; no writes.
- `cs_i` drop coinciding with a data-byte `done_i` in WRITE -> no write; next frame CMD 8'h01 + 8'h99 -> reg1 = 99.
- `rst_i` pulse mid-READ -> `tx_ena_o` 0, all regs `RESET_VAL` next cycle.
